// File: rtl/nt_pkg.sv
// nt_pkg: shared types for the Nixie tube frame controller.
// Holds the value width and the pending-sample bundle.
package nt_pkg;

   localparam int NT_DATA_W = 10;

   typedef logic signed [NT_DATA_W-1:0] nt_value_t;

   typedef struct {
      nt_value_t value;
      logic      ovf;
   } nt_sample_t;

endpackage

// File: rtl/nt_prescaler.sv
// nt_prescaler: scan-phase divider for the Nixie tube frame controller.
// boundary marks the edge that closes a full frame (second half ending).
module nt_prescaler #(
   parameter int SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic scan,
   output logic boundary
);

   localparam int            CW   = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic          wrap;

   assign wrap     = (div_cnt == LAST);
   assign boundary = wrap & scan;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         scan    <= 1'b0;
      end else if (wrap) begin
         div_cnt <= '0;
         scan    <= ~scan;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/nt_frame_ctrl.sv
// nt_frame_ctrl: buffers one sample and commits it at frame boundaries.
// Optional stale-data timeout is enabled by defining NT_TIMEOUT_EN.
import nt_pkg::*;

module nt_frame_ctrl #(
   parameter int SCAN_DIV       = 1000,
   parameter int TIMEOUT_FRAMES = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] in_data,
   input  logic       in_ovf,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [9:0] data,
   output logic       scan,
   output logic       error,
   output logic       frame_tick
);

   logic       boundary;
   logic       accept;
   logic       commit;
   logic       pend_valid;
   logic       have_data;
   logic       ovf_q;
   logic       stale_nxt;
   logic       error_nxt;
   nt_sample_t pend;

   nt_prescaler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .scan     (scan),
      .boundary (boundary)
   );

   // in_ready is kept as its own flop mirroring !pend_valid
   assign accept = in_valid & in_ready;
   assign commit = boundary & pend_valid;

`ifdef NT_TIMEOUT_EN
   localparam int            TW   = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_FRAMES);

   logic [TW-1:0] frame_cnt;
   logic [TW-1:0] frame_cnt_nxt;

   always_comb begin
      frame_cnt_nxt = frame_cnt;
      if (commit)
         frame_cnt_nxt = '0;
      else if (boundary && frame_cnt != TMAX)
         frame_cnt_nxt = frame_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_cnt <= '0;
      else
         frame_cnt <= frame_cnt_nxt;
   end

   assign stale_nxt = (frame_cnt_nxt == TMAX);
`else
   assign stale_nxt = 1'b0;
`endif

   // error is registered from next-state terms so it moves with data
   always_comb begin
      error_nxt = 1'b0;
      if (commit)
         error_nxt = pend.ovf | stale_nxt;
      else
         error_nxt = ~have_data | ovf_q | stale_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend.value <= '0;
         pend.ovf   <= 1'b0;
         pend_valid <= 1'b0;
         in_ready   <= 1'b1;
         data       <= '0;
         have_data  <= 1'b0;
         ovf_q      <= 1'b0;
         frame_tick <= 1'b0;
         error      <= 1'b1;
      end else begin
         frame_tick <= boundary;
         error      <= error_nxt;
         if (accept) begin
            pend.value <= nt_value_t'(in_data);
            pend.ovf   <= in_ovf;
            pend_valid <= 1'b1;
            in_ready   <= 1'b0;
         end
         if (commit) begin
            data       <= pend.value;
            ovf_q      <= pend.ovf;
            have_data  <= 1'b1;
            pend_valid <= 1'b0;
            in_ready   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nt_frame_ctrl.sv
// tb_nt_frame_ctrl: directed scenarios for nt_frame_ctrl.
// Uses SCAN_DIV=4, TIMEOUT_FRAMES=3 (frame = 8 edges).
module tb_nt_frame_ctrl;

   logic       clk;
   logic       rst;
   logic [9:0] in_data;
   logic       in_ovf;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] data;
   logic       scan;
   logic       error;
   logic       frame_tick;

   int passed;
   int total;
   int edge_n;

   nt_frame_ctrl #(
      .SCAN_DIV       (4),
      .TIMEOUT_FRAMES (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_ovf     (in_ovf),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data       (data),
      .scan       (scan),
      .error      (error),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic run_to(input int n);
      while (edge_n < n) step();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      edge_n = 0;
   endtask

   task automatic test_reset();
      do_reset();
      in_data = 10'd77; in_ovf = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      run_to(8);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (data !== 10'd0 || scan !== 1'b0 || error !== 1'b1 ||
          in_ready !== 1'b1 || frame_tick !== 1'b0)
         $display("FAIL reset_async: data=%h scan=%b err=%b rdy=%b tick=%b want 000 0 1 1 0",
                  data, scan, error, in_ready, frame_tick);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      edge_n = 0;
   endtask

   task automatic test_free_run();
      logic exp_scan, exp_tick;
      do_reset();
      for (int e = 1; e <= 24; e++) begin
         step();
         exp_scan = ((e / 4) % 2) == 1;
         exp_tick = (e % 8) == 0;
         total++;
         if (scan !== exp_scan || frame_tick !== exp_tick)
            $display("FAIL free_run edge %0d: scan=%b tick=%b want %b %b",
                     e, scan, frame_tick, exp_scan, exp_tick);
         else passed++;
      end
      total++;
      if (error !== 1'b1)
         $display("FAIL free_run_blank: error=%b want 1", error);
      else passed++;
   endtask

   task automatic test_single();
      do_reset();
      step();
      in_data = 10'h3F6; in_ovf = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0)
         $display("FAIL single_ready_drop: in_ready=%b want 0", in_ready);
      else passed++;
      run_to(7);
      total++;
      if (data !== 10'd0 || error !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL single_pre: data=%h err=%b rdy=%b want 000 1 0",
                  data, error, in_ready);
      else passed++;
      run_to(8);
      total++;
      if (data !== 10'h3F6 || error !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL single_commit: data=%h err=%b rdy=%b want 3f6 0 1",
                  data, error, in_ready);
      else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      in_data = 10'd123; in_ovf = 1'b0; in_valid = 1'b1;
      step();
      in_data = 10'd456;
      run_to(7);
      total++;
      if (in_ready !== 1'b0 || data !== 10'd0)
         $display("FAIL b2b_hold: rdy=%b data=%0d want 0 0", in_ready, data);
      else passed++;
      run_to(8);
      total++;
      if (data !== 10'd123 || in_ready !== 1'b1)
         $display("FAIL b2b_first: data=%0d rdy=%b want 123 1", data, in_ready);
      else passed++;
      step();
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0)
         $display("FAIL b2b_second_accept: rdy=%b want 0", in_ready);
      else passed++;
      run_to(15);
      total++;
      if (data !== 10'd123)
         $display("FAIL b2b_no_tear: data=%0d want 123", data);
      else passed++;
      run_to(16);
      total++;
      if (data !== 10'd456 || in_ready !== 1'b1)
         $display("FAIL b2b_second: data=%0d rdy=%b want 456 1", data, in_ready);
      else passed++;
   endtask

   task automatic test_overflow();
      do_reset();
      in_data = 10'd5; in_ovf = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      run_to(9);
      in_data = 10'd7; in_ovf = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0; in_ovf = 1'b0;
      run_to(15);
      total++;
      if (data !== 10'd5 || error !== 1'b0)
         $display("FAIL ovf_pre: data=%0d err=%b want 5 0", data, error);
      else passed++;
      run_to(16);
      total++;
      if (data !== 10'd7 || error !== 1'b1)
         $display("FAIL ovf_commit: data=%0d err=%b want 7 1", data, error);
      else passed++;
   endtask

   task automatic test_timeout();
      logic exp_err;
`ifdef NT_TIMEOUT_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      do_reset();
      in_data = 10'd5; in_ovf = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      run_to(8);
      total++;
      if (error !== 1'b0)
         $display("FAIL to_commit: error=%b want 0", error);
      else passed++;
      run_to(31);
      total++;
      if (error !== 1'b0)
         $display("FAIL to_before: error=%b want 0", error);
      else passed++;
      run_to(32);
      total++;
      if (error !== exp_err)
         $display("FAIL to_stale: error=%b want %b", error, exp_err);
      else passed++;
      in_data = 10'd9; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      run_to(40);
      total++;
      if (error !== 1'b0 || data !== 10'd9)
         $display("FAIL to_clear: error=%b data=%0d want 0 9", error, data);
      else passed++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      in_data = 10'd5; in_ovf = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      run_to(9);
      in_data = 10'd9; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (data !== 10'd0 || error !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL midrst_now: data=%0d err=%b rdy=%b want 0 1 1",
                  data, error, in_ready);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      edge_n = 0;
      run_to(8);
      total++;
      if (data !== 10'd0 || error !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL midrst_discard: data=%0d err=%b rdy=%b want 0 1 1",
                  data, error, in_ready);
      else passed++;
   endtask

   initial begin
      passed   = 0;
      total    = 0;
      edge_n   = 0;
      rst      = 1'b1;
      in_data  = '0;
      in_ovf   = 1'b0;
      in_valid = 1'b0;
      test_reset();
      test_free_run();
      test_single();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/nt_frame_ctrl.md
# nt_frame_ctrl

Frame controller directly upstream of the 10-bit Nixie tube decoder. It accepts signed 10-bit results from the arithmetic core over a valid/ready handshake and buffers one pending sample. It generates the decoder's scan phase, which alternates tubes 1/3 with tubes 2/4. It commits new values only at frame boundaries so a displayed number never tears between its two halves, and it drives the decoder's error (blank) input.

## Interface
Parameters:
- SCAN_DIV, 1000, clock cycles per scan half-frame; legal range is ≥2.
- TIMEOUT_FRAMES, 250, number of full frames without a commit before data is declared stale; legal range is ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- in_data  in  10  two's-complement value to display
- in_ovf  in  1  upstream overflow flag, qualified by in_valid
- in_valid  in  1  sample offered
- in_ready  out  1  pending buffer empty; a sample is accepted when in_valid & in_ready
- data  out  10  committed value, connected to the decoder's data input
- scan  out  1  scan phase, connected to the decoder's clk input (0 = tubes 1/3, 1 = tubes 2/4)
- error  out  1  blank request, connected to the decoder's error input
- frame_tick  out  1  one-cycle pulse marking each frame boundary

## Operation
Prescaler:
- div_cnt counts 0..SCAN_DIV-1 and then wraps.
- On a wrap, scan toggles.
- A frame boundary is an edge where div_cnt==SCAN_DIV-1 and scan==1. At that edge scan goes to 0 and frame_tick is set for exactly one cycle.

Handshake and pending buffer:
- in_ready = !pend_valid, driven from a register.
- On accept: pend_data ← in_data, pend_ovf ← in_ovf, pend_valid ← 1.
- The source must hold in_valid and in_data until it is accepted.

Commit (at a frame boundary edge, when pend_valid==1):
- data ← pend_data
- ovf_q ← pend_ovf
- have_data ← 1
- pend_valid ← 0
- stale counter ← 0

Simultaneous events:
- Accept while pending is empty on a boundary edge: the sample goes into pending and commits at the next boundary. It never bypasses pending.
- Because in_ready is 0 while pending is full, accept and commit never coincide.

Error:
- error = !have_data | ovf_q | stale.
- Before the first commit the display is blank.

Reset (asynchronous, any time, including mid-frame or with pending full):
- data=0, scan=0, error=1, in_ready=1, frame_tick=0.
- div_cnt=0, pend_valid=0, have_data=0, ovf_q=0, stale=0.
- Any pending sample is discarded.

## Timing
- scan rises at edge SCAN_DIV after reset release and falls at edge 2·SCAN_DIV. The full frame period is 2·SCAN_DIV cycles.
- data, error and the scan falling edge all update on the same edge, the frame boundary.
- frame_tick is high for the one cycle following that edge.
- in_ready drops on the edge after an accept. It returns to 1 on the commit edge.
- Accept-to-display latency: minimum 1 cycle (accept on the cycle just before the boundary), maximum 2·SCAN_DIV cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
NT_TIMEOUT_EN:
- Defined: a frame counter of $clog2(TIMEOUT_FRAMES+1) bits increments at each boundary without a commit and saturates at TIMEOUT_FRAMES. stale=1 while the counter == TIMEOUT_FRAMES. A commit clears it, and error drops on that same edge if the committed ovf=0.
- Undefined: the counter is absent and stale is a constant 0.

## Structure
- Package nt_pkg:
  - NT_DATA_W = 10
  - typedef logic signed [NT_DATA_W-1:0] nt_value_t
  - typedef struct { nt_value_t value; logic ovf; } nt_sample_t
- Sub-module nt_prescaler (parameter SCAN_DIV; outputs scan and boundary). The top level instantiates it once and holds the buffer, commit and error logic.

## Test plan
All scenarios use SCAN_DIV=4 and TIMEOUT_FRAMES=3.

1. Reset: assert rst asynchronously mid-cycle → immediately data=0, scan=0, error=1, in_ready=1, frame_tick=0.
2. Free-run: scan=1 after edges 4–7, 0 after edge 8; frame_tick high only in the cycle after edges 8, 16, 24.
3. Single sample: in_data=10'h3F6 (−10), in_ovf=0, in_valid at cycle 1 → in_ready=0 from cycle 2; at edge 8, data=10'h3F6, error=0, in_ready=1.
4. Back-to-back: 10'd123 is accepted; 10'd456 is held valid → 456 is not accepted until in_ready returns after edge 8. data=123 after edge 8 and 456 after edge 16.
5. Overflow: commit a sample with in_ovf=1, data=10'd7 → data=7 and error=1 on the same boundary edge.
6. Timeout: commit 10'd5, then send no samples. With NT_TIMEOUT_EN defined, error=1 after the third subsequent boundary. Without it, error stays 0.
7. Mid-operation reset: rst asserted with pending full → pending is discarded, error=1, in_ready=1.
